// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster coordinates and strobes; frame_start/frame_cnt only with VGA_TIMING_FRAME_CNT_EN
interface vga_timing_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt);
`else
  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
`endif
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - free-running raster timing generator; optional frame pulse/counter under VGA_TIMING_FRAME_CNT_EN
module vga_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic         pclk,
  input  logic         rst,
  vga_timing_if.master tim_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLNK_START = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_BLNK_START = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_geometry_check
    $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 2048");
  end

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;

  // Strobes are decoded from the next count so they land in the same flop stage as the count.
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      if (vcount_q == V_LAST) begin
        vcount_d = '0;
      end else begin
        vcount_d = vcount_q + 11'd1;
      end
    end
    hblnk_d = (hcount_d >= H_BLNK_START);
    hsync_d = (hcount_d >= H_SYNC_START) && (hcount_d <= H_SYNC_END);
    vblnk_d = (vcount_d >= V_BLNK_START);
    vsync_d = (vcount_d >= V_SYNC_START) && (vcount_d <= V_SYNC_END);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
    end
  end

  assign tim_o.hcount = hcount_q;
  assign tim_o.vcount = vcount_q;
  assign tim_o.hsync  = hsync_q;
  assign tim_o.vsync  = vsync_q;
  assign tim_o.hblnk  = hblnk_q;
  assign tim_o.vblnk  = vblnk_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Reset state is (0,0) too, but the pulse only fires on a real wrap back to the origin.
  always_comb begin
    frame_start_d = (hcount_d == '0) && (vcount_d == '0);
    frame_cnt_d   = frame_cnt_q + {15'd0, frame_start_d};
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign tim_o.frame_start = frame_start_q;
  assign tim_o.frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - raster model check of vga_timing in three geometries with random async resets
module tb_vga_timing;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
    logic [15:0] fc;
  } raster_t;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  vga_timing_if vif_s ();
  vga_timing_if vif_d ();
  vga_timing_if vif_v ();

  vga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(3)
  ) dut_s (.pclk(pclk), .rst(rst), .tim_o(vif_s));

  vga_timing dut_d (.pclk(pclk), .rst(rst), .tim_o(vif_d));

  vga_timing #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2),  .V_BP(33)
  ) dut_v (.pclk(pclk), .rst(rst), .tim_o(vif_v));

  raster_t obs_s, obs_d, obs_v;

  always_comb begin
    obs_s = '0;
    obs_s.h = vif_s.hcount; obs_s.v = vif_s.vcount;
    obs_s.hs = vif_s.hsync; obs_s.vs = vif_s.vsync;
    obs_s.hb = vif_s.hblnk; obs_s.vb = vif_s.vblnk;
`ifdef VGA_TIMING_FRAME_CNT_EN
    obs_s.fs = vif_s.frame_start; obs_s.fc = vif_s.frame_cnt;
`endif
  end

  always_comb begin
    obs_d = '0;
    obs_d.h = vif_d.hcount; obs_d.v = vif_d.vcount;
    obs_d.hs = vif_d.hsync; obs_d.vs = vif_d.vsync;
    obs_d.hb = vif_d.hblnk; obs_d.vb = vif_d.vblnk;
`ifdef VGA_TIMING_FRAME_CNT_EN
    obs_d.fs = vif_d.frame_start; obs_d.fc = vif_d.frame_cnt;
`endif
  end

  always_comb begin
    obs_v = '0;
    obs_v.h = vif_v.hcount; obs_v.v = vif_v.vcount;
    obs_v.hs = vif_v.hsync; obs_v.vs = vif_v.vsync;
    obs_v.hb = vif_v.hblnk; obs_v.vb = vif_v.vblnk;
`ifdef VGA_TIMING_FRAME_CNT_EN
    obs_v.fs = vif_v.frame_start; obs_v.fc = vif_v.frame_cnt;
`endif
  end

  int total = 0;
  int bad   = 0;
  int n     = 0;

  // Expected raster after n clock edges since reset release, from the geometry alone.
  function automatic raster_t model(int cyc, int ha, int hf, int hsw, int hbp,
                                    int va, int vf, int vsw, int vbp);
    raster_t r;
    int ht, vt, x, y;
    ht = ha + hf + hsw + hbp;
    vt = va + vf + vsw + vbp;
    x  = cyc % ht;
    y  = (cyc / ht) % vt;
    r    = '0;
    r.h  = 11'(x);
    r.v  = 11'(y);
    r.hb = (x >= ha);
    r.hs = (x >= ha + hf) && (x < ha + hf + hsw);
    r.vb = (y >= va);
    r.vs = (y >= va + vf) && (y < va + vf + vsw);
`ifdef VGA_TIMING_FRAME_CNT_EN
    r.fs = (cyc > 0) && (cyc % (ht * vt) == 0);
    r.fc = 16'(cyc / (ht * vt));
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input raster_t o, input raster_t e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, o, e);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_s"}, obs_s, model(n, 16, 2, 4, 2, 8, 1, 2, 3));
    chk({tag, "_d"}, obs_d, model(n, 800, 40, 128, 88, 600, 1, 4, 23));
    chk({tag, "_v"}, obs_v, model(n, 640, 16, 96, 48, 480, 10, 2, 33));
  endtask

  int d_hb_rise = -1, d_hs_rise = -1, d_hs_last = -1, d_wrap_n = -1, d_wrap_h = -1;
  int v_hs_rise = -1, v_hs_last = -1, v_wrap_n = -1;
  int s_period = -1, s_vs_lines = 0;

  initial begin
    raster_t zero;
    zero = '0;

    rst = 1'b1;
    repeat (3) @(negedge pclk);
    chk("reset_s", obs_s, zero);
    chk("reset_d", obs_d, zero);
    chk("reset_v", obs_v, zero);

    rst = 1'b0;
    n   = 0;
    for (int i = 0; i < 1700; i++) begin
      @(negedge pclk);
      n++;
      check_all("run");
      if (vif_d.hblnk && d_hb_rise < 0) d_hb_rise = n;
      if (vif_d.hsync && n < 1056) begin
        if (d_hs_rise < 0) d_hs_rise = n;
        d_hs_last = n;
      end
      if (vif_d.vcount == 11'd1 && d_wrap_n < 0) begin
        d_wrap_n = n;
        d_wrap_h = int'(vif_d.hcount);
      end
      if (vif_v.hsync && n < 800) begin
        if (v_hs_rise < 0) v_hs_rise = n;
        v_hs_last = n;
      end
      if (vif_v.vcount == 11'd1 && v_wrap_n < 0) v_wrap_n = n;
      if (n > 0 && vif_s.hcount == 11'd0 && vif_s.vcount == 11'd0 && s_period < 0) s_period = n;
      if (n <= 336 && vif_s.vsync && vif_s.hcount == 11'd0) s_vs_lines++;
    end

    chk_int("d_hblnk_rise", d_hb_rise, 800);
    chk_int("d_hsync_rise", d_hs_rise, 840);
    chk_int("d_hsync_last", d_hs_last, 967);
    chk_int("d_line_wrap_n", d_wrap_n, 1056);
    chk_int("d_line_wrap_h", d_wrap_h, 0);
    chk_int("v_hsync_rise", v_hs_rise, 656);
    chk_int("v_hsync_last", v_hs_last, 751);
    chk_int("v_line_wrap_n", v_wrap_n, 800);
    chk_int("s_frame_period", s_period, 24 * 14);
    chk_int("s_vsync_lines", s_vs_lines, 2);

    for (int k = 0; k < 8; k++) begin
      int run_len;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_s", obs_s, zero);
      chk("async_rst_d", obs_d, zero);
      chk("async_rst_v", obs_v, zero);
      repeat ($urandom_range(1, 3)) @(negedge pclk);
      chk("held_rst_s", obs_s, zero);
      rst = 1'b0;
      n   = 0;
      run_len = (k == 0) ? 130 : int'($urandom_range(30, 600));
      for (int i = 0; i < run_len; i++) begin
        @(negedge pclk);
        n++;
        check_all("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
